// File: rtl/pattern_resp_misr.sv
// Response compactor: folds accepted pattern-stage outputs into a MISR over a
// programmed window, then reports done/match until acknowledged.
module pattern_resp_misr #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021,
    parameter logic [SIG_W-1:0] SEED = 16'h0000,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic [CNT_W-1:0]  win_len,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    input  logic [SIG_W-1:0]  expect_sig,
    input  logic              abort,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  resp_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SIG_W-1:0]   resp_ext;
    logic [SIG_W-1:0]   sig_next;

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        resp_ext = '0;
        resp_ext[DATA_W-1:0] = resp_data;
        sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ resp_ext;
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        if (abort) begin
            // abort outranks every other request; signature is kept for inspection
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (win_len != '0)) begin
                        state_d = ST_RUN;
                        sig_d   = SEED;
                        cnt_d   = win_len;
                    end
                end
                ST_RUN: begin
                    if (resp_valid && (cnt_q != '0)) begin
                        sig_d = sig_next;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign match      = done && (sig_q == expect_sig);
    assign signature  = sig_q;
    assign resp_count = cnt_q;

endmodule

// File: tb/tb_pattern_resp_misr.sv
// Directed self-checking bench for pattern_resp_misr with hand-computed signatures.
module tb_pattern_resp_misr;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  win_len;
    logic        resp_valid;
    logic [10:0] resp_data;
    logic [15:0] expect_sig;
    logic        abort;
    logic        ack;
    logic        busy;
    logic        done;
    logic        match;
    logic [15:0] signature;
    logic [7:0]  resp_count;

    int tests = 0;
    int fails = 0;

    pattern_resp_misr #(
        .DATA_W(11),
        .SIG_W (16),
        .POLY  (16'h1021),
        .SEED  (16'h0000),
        .CNT_W (8)
    ) dut (
        .blif_clk_net  (clk),
        .blif_reset_net(rst_n),
        .start         (start),
        .win_len       (win_len),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .expect_sig    (expect_sig),
        .abort         (abort),
        .ack           (ack),
        .busy          (busy),
        .done          (done),
        .match         (match),
        .signature     (signature),
        .resp_count    (resp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; win_len = '0; resp_valid = 0; resp_data = '0;
        expect_sig = '0; abort = 0; ack = 0;
        #3;
        tests++; if (signature !== 16'h0000) begin fails++; $display("FAIL reset_sig got=%h exp=0000", signature); end
        tests++; if ({busy, done, match} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b exp=000", {busy, done, match}); end
        tests++; if (resp_count !== 8'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", resp_count); end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic_window;
        start = 1; win_len = 8'd2; tick; start = 0;
        tests++; if (busy !== 1'b1 || resp_count !== 8'd2) begin fails++; $display("FAIL basic_start busy=%b cnt=%0d exp busy=1 cnt=2", busy, resp_count); end
        resp_valid = 1; resp_data = 11'h001; tick;
        tests++; if (signature !== 16'h0001 || resp_count !== 8'd1) begin fails++; $display("FAIL basic_r1 sig=%h cnt=%0d exp sig=0001 cnt=1", signature, resp_count); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_early_done got=%b exp=0", done); end
        tick; resp_valid = 0;
        tests++; if (signature !== 16'h0003 || done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL basic_r2 sig=%h done=%b busy=%b exp sig=0003 done=1 busy=0", signature, done, busy); end
        expect_sig = 16'h0003; #1;
        tests++; if (match !== 1'b1) begin fails++; $display("FAIL basic_match got=%b exp=1", match); end
        expect_sig = 16'h0004; #1;
        tests++; if (match !== 1'b0) begin fails++; $display("FAIL basic_nomatch got=%b exp=0", match); end
        ack = 1; tick; ack = 0;
        tests++; if (done !== 1'b0 || signature !== 16'h0003) begin fails++; $display("FAIL basic_ack done=%b sig=%h exp done=0 sig=0003", done, signature); end
    endtask

    task automatic test_feedback_tap;
        start = 1; win_len = 8'd17; tick; start = 0;
        resp_valid = 1; resp_data = 11'h001; tick;
        resp_data = 11'h000;
        for (int i = 0; i < 15; i++) tick;
        tests++; if (signature !== 16'h8000 || resp_count !== 8'd1) begin fails++; $display("FAIL fb_msb sig=%h cnt=%0d exp sig=8000 cnt=1", signature, resp_count); end
        tick; resp_valid = 0;
        tests++; if (signature !== 16'h1021 || done !== 1'b1) begin fails++; $display("FAIL fb_poly sig=%h done=%b exp sig=1021 done=1", signature, done); end
        expect_sig = 16'h1021; #1;
        tests++; if (match !== 1'b1) begin fails++; $display("FAIL fb_match got=%b exp=1", match); end
        ack = 1; tick; ack = 0;
    endtask

    task automatic test_stalls;
        logic [7:0] exp_cnt;
        exp_cnt = 8'd3;
        start = 1; win_len = 8'd3; tick; start = 0;
        for (int c = 1; c <= 9; c++) begin
            resp_valid = (c == 1) || (c == 4) || (c == 9);
            resp_data  = (c == 1) ? 11'h005 : (c == 4) ? 11'h00A : (c == 9) ? 11'h100 : 11'h7FF;
            tick;
            if (resp_valid) exp_cnt = exp_cnt - 8'd1;
            tests++; if (resp_count !== exp_cnt) begin fails++; $display("FAIL stall_cnt c=%0d got=%0d exp=%0d", c, resp_count, exp_cnt); end
            tests++; if (done !== (c == 9)) begin fails++; $display("FAIL stall_done c=%0d got=%b exp=%b", c, done, (c == 9)); end
        end
        resp_valid = 0;
        tests++; if (signature !== 16'h0100) begin fails++; $display("FAIL stall_sig got=%h exp=0100", signature); end
        ack = 1; tick; ack = 0;
    endtask

    task automatic test_zero_and_abort;
        start = 1; win_len = 8'd0; tick; start = 0;
        tests++; if (busy !== 1'b0 || resp_count !== 8'd0 || signature !== 16'h0100) begin fails++; $display("FAIL zero_len busy=%b cnt=%0d sig=%h exp busy=0 cnt=0 sig=0100", busy, resp_count, signature); end
        start = 1; win_len = 8'd2; tick; start = 0;
        tests++; if (busy !== 1'b1 || signature !== 16'h0000) begin fails++; $display("FAIL reseed busy=%b sig=%h exp busy=1 sig=0000", busy, signature); end
        resp_valid = 1; resp_data = 11'h7FF; tick; resp_valid = 0;
        start = 1; win_len = 8'd9; tick; start = 0;
        tests++; if (resp_count !== 8'd1 || signature !== 16'h07FF || busy !== 1'b1) begin fails++; $display("FAIL run_start cnt=%0d sig=%h busy=%b exp cnt=1 sig=07ff busy=1", resp_count, signature, busy); end
        resp_valid = 1; resp_data = 11'h001; abort = 1; tick; resp_valid = 0; abort = 0;
        tests++; if (busy !== 1'b0 || done !== 1'b0 || resp_count !== 8'd0 || signature !== 16'h07FF) begin fails++; $display("FAIL abort busy=%b done=%b cnt=%0d sig=%h exp 0 0 0 07ff", busy, done, resp_count, signature); end
        tick;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_late_done got=%b exp=0", done); end
    endtask

    task automatic test_ack_start;
        start = 1; win_len = 8'd1; tick; start = 0;
        resp_valid = 1; resp_data = 11'h003; tick; resp_valid = 0;
        tests++; if (done !== 1'b1 || signature !== 16'h0003) begin fails++; $display("FAIL ackst_done done=%b sig=%h exp done=1 sig=0003", done, signature); end
        ack = 1; start = 1; win_len = 8'd5; tick; ack = 0; start = 0;
        tests++; if (done !== 1'b0 || busy !== 1'b0 || resp_count !== 8'd0) begin fails++; $display("FAIL ackst_idle done=%b busy=%b cnt=%0d exp 0 0 0", done, busy, resp_count); end
        tick;
        tests++; if (busy !== 1'b0 || signature !== 16'h0003) begin fails++; $display("FAIL ackst_hold busy=%b sig=%h exp busy=0 sig=0003", busy, signature); end
    endtask

    task automatic test_reset_mid_run;
        start = 1; win_len = 8'd4; tick; start = 0;
        resp_valid = 1; resp_data = 11'h001; tick; tick; resp_valid = 0;
        tests++; if (signature !== 16'h0003 || resp_count !== 8'd2) begin fails++; $display("FAIL rst_pre sig=%h cnt=%0d exp sig=0003 cnt=2", signature, resp_count); end
        #1; rst_n = 1'b0; #1;
        tests++; if (signature !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || resp_count !== 8'd0) begin fails++; $display("FAIL rst_async sig=%h busy=%b done=%b cnt=%0d exp 0000 0 0 0", signature, busy, done, resp_count); end
        @(negedge clk); rst_n = 1'b1; tick;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_after busy=%b exp=0", busy); end
    endtask

    initial begin
        test_reset;
        test_basic_window;
        test_feedback_tap;
        test_stalls;
        test_zero_and_abort;
        test_ack_start;
        test_reset_mid_run;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
